// File: rtl/dump_sched_pkg.sv
// Shared types and constants for the dump scheduler.
// Optional build macro: DUMP_SCHEDULER_FLAG_CHANGE_EN (any-change event detection).
package dump_sched_pkg;

    localparam int unsigned NUM_CHAN_DEFAULT = 4;
    localparam int unsigned CHAN_W           = $clog2(NUM_CHAN_DEFAULT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOffer = 2'd1,
        StBusy  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/dump_edge_det.sv
// Per-channel dump event detector with history bit and post-reset suppression.
// Macro DUMP_SCHEDULER_FLAG_CHANGE_EN: any level change is an event; otherwise rising edges only.
module dump_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic i_dump,
    output logic o_event
);

    logic r_hist;
    logic r_suppress;
    logic w_edge;

`ifdef DUMP_SCHEDULER_FLAG_CHANGE_EN
    assign w_edge = i_dump ^ r_hist;
`else
    assign w_edge = i_dump & ~r_hist;
`endif

    // History is cleared by reset, so a channel already high would look like an edge.
    assign o_event = w_edge & ~r_suppress;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist     <= 1'b0;
            r_suppress <= 1'b1;
        end else begin
            r_hist     <= i_dump;
            r_suppress <= 1'b0;
        end
    end

endmodule

// File: rtl/dump_scheduler.sv
// Round-robin scheduler granting per-channel accumulator dumps to one loop processor.
// Macro DUMP_SCHEDULER_FLAG_CHANGE_EN selects any-change events in dump_edge_det.
module dump_scheduler
    import dump_sched_pkg::*;
#(
    parameter int unsigned NUM_CHAN = NUM_CHAN_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_CHAN-1:0]         dump_in,
    output logic                        grant_valid,
    output logic [$clog2(NUM_CHAN)-1:0] grant_chan,
    input  logic                        grant_ready,
    input  logic                        proc_done,
    output logic                        busy,
    output logic [NUM_CHAN-1:0]         overflow,
    input  logic                        overflow_clr
);

    localparam int unsigned W    = $clog2(NUM_CHAN);
    localparam logic [W-1:0] LAST = W'(NUM_CHAN - 1);

    sched_state_e        r_state, w_state_d;
    logic [W-1:0]        r_grant_chan, w_grant_chan_d;
    logic [W-1:0]        r_rr_ptr, w_rr_ptr_d;
    logic [W-1:0]        w_sel;
    logic                w_found;
    logic                w_hs;
    logic [NUM_CHAN-1:0] r_pending, w_pending_d;
    logic [NUM_CHAN-1:0] r_overflow, w_overflow_d;
    logic [NUM_CHAN-1:0] w_event;
    logic [NUM_CHAN-1:0] w_clr;

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        dump_edge_det u_det (
            .clk     (clk),
            .reset_n (reset_n),
            .i_dump  (dump_in[gi]),
            .o_event (w_event[gi])
        );
    end

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned k = 0; k < NUM_CHAN; k++) begin
            idx = (32'(r_rr_ptr) + k) % NUM_CHAN;
            if (!w_found && r_pending[idx]) begin
                w_found = 1'b1;
                w_sel   = W'(idx);
            end
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_grant_chan_d = r_grant_chan;
        w_rr_ptr_d     = r_rr_ptr;
        w_hs           = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_state_d      = StOffer;
                    w_grant_chan_d = w_sel;
                end
            end
            StOffer: begin
                if (grant_ready) begin
                    w_hs       = 1'b1;
                    w_state_d  = StBusy;
                    w_rr_ptr_d = (r_grant_chan == LAST) ? '0 : r_grant_chan + W'(1);
                end
            end
            StBusy: begin
                if (proc_done) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        for (int i = 0; i < NUM_CHAN; i++) begin
            w_clr[i] = w_hs && (r_grant_chan == W'(i));
        end

        // A same-cycle event re-arms a channel being cleared, so it is not an overflow.
        w_pending_d  = (r_pending & ~w_clr) | w_event;
        w_overflow_d = (overflow_clr ? '0 : r_overflow) | (w_event & r_pending & ~w_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_grant_chan <= '0;
            r_rr_ptr     <= '0;
            r_pending    <= '0;
            r_overflow   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_grant_chan <= w_grant_chan_d;
            r_rr_ptr     <= w_rr_ptr_d;
            r_pending    <= w_pending_d;
            r_overflow   <= w_overflow_d;
        end
    end

    assign grant_valid = (r_state == StOffer);
    assign busy        = (r_state == StBusy);
    assign grant_chan  = r_grant_chan;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_dump_scheduler.sv
// Directed self-checking bench for dump_scheduler (NUM_CHAN = 4).
// Honours DUMP_SCHEDULER_FLAG_CHANGE_EN when choosing the falling-edge expectation.
module tb_dump_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] dump_in;
    logic       grant_valid;
    logic [1:0] grant_chan;
    logic       grant_ready;
    logic       proc_done;
    logic       busy;
    logic [3:0] overflow;
    logic       overflow_clr;

    int checks = 0;
    int errors = 0;

    dump_scheduler #(
        .NUM_CHAN (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dump_in      (dump_in),
        .grant_valid  (grant_valid),
        .grant_chan   (grant_chan),
        .grant_ready  (grant_ready),
        .proc_done    (proc_done),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] din);
        dump_in      = din;
        grant_ready  = 1'b0;
        proc_done    = 1'b0;
        overflow_clr = 1'b0;
        reset_n      = 1'b0;
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset(4'b0000);
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_gv: got %0b expected 0", grant_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b expected 0", busy);
        end
        checks++;
        if (grant_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_chan: got %0d expected 0", grant_chan);
        end
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0000", overflow);
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: got busy=%0b gv=%0b expected 0 0", busy, grant_valid);
        end
    endtask

    task automatic test_single_grant();
        do_reset(4'b0000);
        dump_in = 4'b0100;
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got gv=%0b expected 0", grant_valid);
        end
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_chan !== 2'd2) begin
            errors++;
            $display("FAIL single_offer: got gv=%0b chan=%0d expected 1 2", grant_valid, grant_chan);
        end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got busy=%0b gv=%0b expected 1 0", busy, grant_valid);
        end
        tick();
        tick();
        proc_done = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: got busy=%0b expected 1", busy);
        end
        tick();
        proc_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%0b gv=%0b expected 0 0", busy, grant_valid);
        end
        tick();
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_regrant: got gv=%0b expected 0", grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order [3];
        int n;
        exp_order = '{2'd1, 2'd3, 2'd0};
        do_reset(4'b0000);
        dump_in = 4'b0001;
        tick();
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        proc_done   = 1'b1;
        tick();
        proc_done = 1'b0;
        dump_in   = 4'b0000;
        tick();
        dump_in = 4'b1011;
        tick();
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (grant_valid !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (grant_valid !== 1'b1 || grant_chan !== exp_order[g]) begin
                errors++;
                $display("FAIL rr_order%0d: got gv=%0b chan=%0d expected 1 %0d",
                         g, grant_valid, grant_chan, exp_order[g]);
            end
            grant_ready = 1'b1;
            tick();
            grant_ready = 1'b0;
            proc_done   = 1'b1;
            tick();
            proc_done = 1'b0;
        end
    endtask

    task automatic test_overflow();
        do_reset(4'b0000);
        dump_in = 4'b0001;
        tick();
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        dump_in = 4'b0011;
        tick();
        dump_in = 4'b0001;
        tick();
        dump_in = 4'b0011;
        tick();
        checks++;
        if (overflow !== 4'b0010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b busy=%0b expected 0010 1", overflow, busy);
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_chan !== 2'd1 || overflow !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_sticky: got gv=%0b chan=%0d ovf=%b expected 1 1 0010",
                     grant_valid, grant_chan, overflow);
        end
        dump_in = 4'b0001;
        tick();
        dump_in      = 4'b0011;
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 0010", overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0000", overflow);
        end
        dump_in = 4'b0001;
        tick();
        dump_in     = 4'b0011;
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL hs_event: got busy=%0b ovf=%b expected 1 0000", busy, overflow);
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        tick();
        checks++;
        if (grant_valid !== 1'b1 || grant_chan !== 2'd1) begin
            errors++;
            $display("FAIL hs_repend: got gv=%0b chan=%0d expected 1 1", grant_valid, grant_chan);
        end
    endtask

    task automatic test_reset_high();
        int grants;
        grants = 0;
        do_reset(4'b1111);
        for (int c = 0; c < 20; c++) begin
            if (grant_valid === 1'b1) grants++;
            tick();
        end
        checks++;
        if (grants !== 0 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL high_at_reset: got grants=%0d ovf=%b expected 0 0000", grants, overflow);
        end
    endtask

    task automatic test_falling_edge();
        do_reset(4'b1000);
        dump_in = 4'b0000;
        tick();
        tick();
`ifdef DUMP_SCHEDULER_FLAG_CHANGE_EN
        checks++;
        if (grant_valid !== 1'b1 || grant_chan !== 2'd3) begin
            errors++;
            $display("FAIL fall_grant: got gv=%0b chan=%0d expected 1 3", grant_valid, grant_chan);
        end
`else
        tick();
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL fall_nogrant: got gv=%0b expected 0", grant_valid);
        end
`endif
    endtask

    task automatic test_reset_in_offer();
        int grants;
        grants = 0;
        do_reset(4'b0000);
        dump_in = 4'b0100;
        tick();
        tick();
        checks++;
        if (grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_offer: got gv=%0b expected 1", grant_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || grant_chan !== 2'd0) begin
            errors++;
            $display("FAIL abort_async: got gv=%0b busy=%0b chan=%0d expected 0 0 0",
                     grant_valid, busy, grant_chan);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (grant_valid === 1'b1) grants++;
            tick();
        end
        checks++;
        if (grants !== 0) begin
            errors++;
            $display("FAIL abort_pending: got grants=%0d expected 0", grants);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        dump_in      = '0;
        grant_ready  = 1'b0;
        proc_done    = 1'b0;
        overflow_clr = 1'b0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_overflow();
        test_reset_high();
        test_falling_edge();
        test_reset_in_offer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dump_scheduler.md
DUMP_SCHEDULER -- requirements
Module: dump_scheduler

Interface
REQ-001 Parameter NUM_CHAN, default 4: number of tracking channels sharing the loop processor (2..16).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 dump_in  input  NUM_CHAN  per-channel accumulator-dump flag; a level that channels toggle or raise.
REQ-005 grant_valid  output  1  a dump grant is offered to the loop processor.
REQ-006 grant_chan  output  clog2(NUM_CHAN)  index of the channel offered or being serviced.
REQ-007 grant_ready  input  1  processor accepts the offered grant.
REQ-008 proc_done  input  1  single-cycle pulse: processor has finished the granted channel.
REQ-009 busy  output  1  a granted channel is being serviced.
REQ-010 overflow  output  NUM_CHAN  sticky per-channel flag: a dump was lost.
REQ-011 overflow_clr  input  1  synchronous clear of all overflow bits.

Function
REQ-012 Each channel SHALL keep a history bit; an event occurs in cycle N when dump_in[i]=1 and history[i]=0.
REQ-013 The history SHALL update to dump_in every cycle; an event in cycle N SHALL set pending[i], visible in cycle N+1.
REQ-014 Events SHALL be suppressed in the first cycle after reset deassertion, so channels high at reset produce no event.
REQ-015 FSM states: IDLE, OFFER, BUSY; the reset state SHALL be IDLE.
REQ-016 IDLE with any pending bit set SHALL go to OFFER next cycle, latching grant_chan = first pending channel at or after rr_ptr, wrapping modulo NUM_CHAN.
REQ-017 In OFFER, grant_valid=1 and grant_chan SHALL hold stable until grant_ready=1.
REQ-018 A handshake (grant_valid & grant_ready) SHALL clear pending[grant_chan], set rr_ptr = grant_chan+1 mod NUM_CHAN, and go to BUSY.
REQ-019 In BUSY, busy=1 and grant_valid=0; proc_done SHALL return the FSM to IDLE; proc_done outside BUSY SHALL be ignored.
REQ-020 Worst-case latency from an event to grant_valid SHALL be 2 cycles when the FSM is IDLE.
REQ-021 An event on a channel whose pending bit is already set, and is not being cleared that cycle, SHALL set overflow[i].
REQ-022 An event in the handshake cycle of the same channel SHALL re-set pending[i] without raising overflow.
REQ-023 When overflow_clr and a new overflow coincide, the set SHALL win.

Reset
REQ-024 Reset SHALL take effect immediately: FSM=IDLE, pending=0, history=0, rr_ptr=0, overflow=0, grant_valid=0, grant_chan=0, busy=0, event suppression armed.
REQ-025 Reset asserted in OFFER or BUSY SHALL abandon the grant; no pending state survives.

Configuration
REQ-026 Macro DUMP_SCHEDULER_FLAG_CHANGE_EN: when defined, an event is any change (dump_in[i] != history[i]); when undefined, only rising edges are events.

Structure
REQ-027 Package dump_sched_pkg SHALL hold the FSM state typedef, the NUM_CHAN default and the CHAN_W width constant.
REQ-028 The per-channel history bit, first-cycle suppression and event logic SHALL be sub-module dump_edge_det, instantiated NUM_CHAN times.

Verification (NUM_CHAN=4, macro undefined unless noted)
REQ-029 dump_in[2] rises in cycle 10 with the FSM idle -> grant_valid=1, grant_chan=2 in cycle 12; grant_ready in 12 -> busy=1 in 13; proc_done in 15 -> IDLE in 16.
REQ-030 dump_in[0,1,3] rise together with rr_ptr=1 -> grants are issued in order 1, 3, 0.
REQ-031 dump_in[1] toggles 0->1->0->1 while pending[1] is set and the FSM is BUSY -> overflow[1]=1 and stays set until overflow_clr.
REQ-032 dump_in=4'b1111 held through reset release -> no grant within 20 cycles.
REQ-033 With the macro defined, dump_in[3] falls 1->0 -> grant_chan=3 two cycles later; without the macro -> no grant.
REQ-034 reset_n pulsed low during OFFER -> grant_valid=0 asynchronously, pending=0, FSM=IDLE.
